// File: rtl/trunc_ctrl_if.sv
// ============================================================================
//  Module  : trunc_ctrl_if
//  Brief   : Sample-in / truncation-code-out handshake bundle for trunc_ctrl.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface trunc_ctrl_if #(
    parameter int N = 5
) ();
    logic [N-1:0] s_data;
    logic         s_valid;
    logic         s_ready;
    logic         flush;
    logic [N-2:0] m_truncator;
    logic         m_valid;
    logic         m_ready;
    logic [7:0]   m_count;

    // slave: the trunc_ctrl block itself; master: the surrounding source/sink
    modport slave (
        input  s_data, s_valid, flush, m_ready,
        output s_ready, m_truncator, m_valid, m_count
    );

    modport master (
        output s_data, s_valid, flush, m_ready,
        input  s_ready, m_truncator, m_valid, m_count
    );
endinterface

`default_nettype wire

// File: rtl/trunc_ctrl.sv
// ============================================================================
//  Module  : trunc_ctrl
//  Brief   : ORs a block of samples together and emits a one-hot truncation
//            code derived from the highest set bit of the block.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module trunc_ctrl #(
    parameter int N       = 5,
    parameter int BLK_LEN = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    trunc_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [8:0] C_BLK_LEN = 9'(BLK_LEN);

    state_t       state_q, state_d;
    logic [N-1:0] acc_q, acc_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [N-2:0] code_q, code_d;
    logic [7:0]   count_q, count_d;

    logic         w_xfer;
    logic         w_close;
    logic [N-1:0] w_acc_next;
    logic [8:0]   w_cnt_next;
    logic [N-2:0] w_code;

    // Count is widened by one bit so BLK_LEN=256 can be detected; m_count
    // then reports the low 8 bits.
    always_comb begin
        w_xfer     = bus.s_valid && (state_q == ACCUM);
        w_acc_next = acc_q | (w_xfer ? bus.s_data : '0);
        w_cnt_next = {1'b0, cnt_q} + {8'd0, w_xfer};
        w_close    = (state_q == ACCUM) && (bus.flush || (w_cnt_next == C_BLK_LEN));
    end

    // Bit p (p>=1) marks v[p-1] as the highest set bit; the top two bit
    // positions of v map to all-zeros, i.e. no truncation.
    always_comb begin
        w_code    = '0;
        w_code[0] = ~|w_acc_next;
        for (int p = 1; p <= N - 2; p++) begin
            w_code[p] = w_acc_next[p-1] & ~|(w_acc_next >> p);
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        count_d = count_q;
        case (state_q)
            ACCUM: begin
                acc_d = w_acc_next;
                cnt_d = w_cnt_next[7:0];
                if (w_close) begin
                    state_d = HOLD;
                    acc_d   = '0;
                    cnt_d   = '0;
                    code_d  = w_code;
                    count_d = w_cnt_next[7:0];
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    state_d = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            count_q <= count_d;
        end
    end

    assign bus.s_ready     = (state_q == ACCUM);
    assign bus.m_valid     = (state_q == HOLD);
    assign bus.m_truncator = code_q;
    assign bus.m_count     = count_q;

endmodule

`default_nettype wire

// File: doc/trunc_ctrl.md
TRUNC_CTRL -- requirements
Module: trunc_ctrl

Interface
REQ-001 Parameter N, default 5: sample width; the generated code is N-1 bits wide.
REQ-002 Parameter BLK_LEN, default 8: samples per block, range 2..256.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 s_data  input  N  unsigned sample from the upstream source.
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_ready  output  1  block accepts a sample this cycle.
REQ-008 flush  input  1  close the current block early, single-cycle pulse.
REQ-009 m_truncator  output  N-1  truncation code for the downstream trunc stage.
REQ-010 m_valid  output  1  m_truncator valid.
REQ-011 m_ready  input  1  downstream consumes the code.
REQ-012 m_count  output  8  number of samples in the block that produced m_truncator.

Function
REQ-013 Sample transfer SHALL occur when s_valid and s_ready are both high on a rising edge.
REQ-014 Code transfer SHALL occur when m_valid and m_ready are both high on a rising edge.
REQ-015 The FSM SHALL have exactly two states: ACCUM and HOLD.
REQ-016 In ACCUM: s_ready=1 and m_valid=0.
REQ-017 In HOLD: s_ready=0, m_valid=1, and m_truncator and m_count are stable until transfer.
REQ-018 In ACCUM, each transfer SHALL OR s_data into an N-bit accumulator acc and increment the 8-bit counter cnt.
REQ-019 The block SHALL close when a transfer makes cnt reach BLK_LEN, or when flush=1 in ACCUM.
REQ-020 On close, the state SHALL become HOLD on the next edge, and acc and cnt SHALL clear to 0 on that same edge.
REQ-021 If flush coincides with a transfer, that sample SHALL be included in the closing block.
REQ-022 Let v be the final acc value, including any coincident sample.
REQ-023 Let h be the index of the highest set bit of v.
REQ-024 Code rule: v=0 gives m_truncator one-hot bit 0.
REQ-025 Code rule: h <= N-3 gives m_truncator one-hot bit h+1.
REQ-026 Code rule: h >= N-2 gives m_truncator all zeros (no truncation).
REQ-027 Downstream interpretation: one-hot bit p means keep signal bits [p-1:0]; all zeros means pass through unchanged.
REQ-028 m_count SHALL equal the number of samples in the block, including any coincident sample.
REQ-029 flush in ACCUM with cnt=0 and no transfer SHALL close an empty block: code one-hot bit 0, m_count=0.
REQ-030 flush in HOLD SHALL be ignored.
REQ-031 In HOLD, a code transfer SHALL return the FSM to ACCUM on the next edge.
REQ-032 Latency: m_valid SHALL rise exactly one cycle after the closing edge; there is no combinational path from s_data to m_truncator.
REQ-033 Throughput: at most one block per BLK_LEN+1 cycles, because there is one HOLD cycle minimum.
REQ-034 m_ready high in ACCUM SHALL have no effect.

Reset
REQ-035 rst high SHALL immediately force ACCUM, acc=0, cnt=0, m_valid=0, m_truncator=0 and m_count=0, regardless of clk.
REQ-036 After reset, s_ready SHALL be 1.
REQ-037 Reset mid-block SHALL discard partial acc and cnt.
REQ-038 Reset in HOLD SHALL drop the pending code without a transfer.
REQ-039 The first block after reset release SHALL start from cnt=0.

Verification
REQ-040 Scenario (N=5, BLK_LEN=8): 8 transfers of 5'b00011, m_ready=1 -> m_truncator=4'b0100 and m_count=8, m_valid for 1 cycle.
REQ-041 Scenario: 8 transfers including one 5'b01000, rest 0 -> m_truncator=4'b0000.
REQ-042 Scenario: 3 transfers of 5'b00001, then flush with no transfer -> m_truncator=4'b0010, m_count=3.
REQ-043 Scenario: flush coincident with the 2nd transfer (5'b00100) -> m_truncator=4'b1000, m_count=2; the next sample lands in a new block.
REQ-044 Scenario: HOLD with m_ready=0 for 5 cycles -> s_ready=0 and outputs stable throughout; m_ready=1 -> ACCUM on the next edge.
REQ-045 Scenario: rst asserted asynchronously after 4 transfers and also while in HOLD -> outputs zero immediately; the next block counts from 0.
